syn_fifo_param: RTL and testbench

Parametrised synchronous FIFO that succeeds the fixed-configuration `syn_fifo` family in the memory library. Depth, width and almost-full/almost-empty thresholds are set per instance. It adds an occupancy count, registered overflow/underflow error pulses, and an optional first-word-fall-through read mode. It sits between same-clock producer and consumer blocks as the standard buffering element.

---
 rtl/syn_fifo_param_if.sv | 30 +++
 rtl/syn_fifo_param.sv | 85 ++++++++
 tb/tb_syn_fifo_param.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/syn_fifo_param_if.sv
// Handshake/data bundle for syn_fifo_param: producer/consumer side is the
// master modport, the FIFO itself is the slave.
interface syn_fifo_param_if #(
    parameter int unsigned data_width = 8,
    parameter int unsigned addr_width = 4
) ();
    logic                  w_en;
    logic                  r_en;
    logic [data_width-1:0] data_in;
    logic [data_width-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [addr_width:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output w_en, r_en, data_in,
        input  data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  w_en, r_en, data_in,
        output data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/syn_fifo_param.sv
// Parametrised synchronous FIFO with occupancy count and registered error pulses.
// Define SYN_FIFO_FWFT_EN for first-word-fall-through (combinational head word) reads.
module syn_fifo_param #(
    parameter int unsigned data_width = 8,
    parameter int unsigned addr_width = 4,
    parameter int unsigned af_level   = (2 ** addr_width) - 2,
    parameter int unsigned ae_level   = 2
) (
    input logic             clk,
    input logic             clr,
    syn_fifo_param_if.slave bus
);
    localparam int unsigned       depth     = 2 ** addr_width;
    localparam logic [addr_width:0] depth_cnt = (addr_width + 1)'(depth);
    localparam logic [addr_width:0] af_cnt    = (addr_width + 1)'(af_level);
    localparam logic [addr_width:0] ae_cnt    = (addr_width + 1)'(ae_level);

    logic [data_width-1:0] mem [depth];
    logic [addr_width-1:0] wp;
    logic [addr_width-1:0] rp;
    logic [addr_width:0]   count_q;
    logic                  ovf_q;
    logic                  udf_q;
    logic                  full_c;
    logic                  empty_c;
    logic                  rd_acc;
    logic                  wr_acc;

    assign full_c  = (count_q == depth_cnt);
    assign empty_c = (count_q == '0);

    // A read frees a slot in the same edge, so a full FIFO can still take a write.
    assign rd_acc = bus.r_en & ~empty_c;
    assign wr_acc = bus.w_en & (~full_c | rd_acc);

    always_ff @(posedge clk) begin
        if (!clr && wr_acc) begin
            mem[wp] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wp      <= '0;
            rp      <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (wr_acc) wp <= wp + addr_width'(1);
            if (rd_acc) rp <= rp + addr_width'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + (addr_width + 1)'(1);
                2'b01:   count_q <= count_q - (addr_width + 1)'(1);
                default: count_q <= count_q;
            endcase
            ovf_q <= bus.w_en & full_c & ~bus.r_en;
            udf_q <= bus.r_en & empty_c;
        end
    end

`ifdef SYN_FIFO_FWFT_EN
    assign bus.data_out = mem[rp];
`else
    logic [data_width-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            dout_q <= '0;
        end else if (rd_acc) begin
            dout_q <= mem[rp];
        end
    end

    assign bus.data_out = dout_q;
`endif

    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.almost_full  = (count_q >= af_cnt);
    assign bus.almost_empty = (count_q <= ae_cnt);
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_syn_fifo_param.sv
// Bench for syn_fifo_param (default parameters): table of steps with expected
// count/error pulses, read data tracked by a model queue and a scoreboard.
module tb_syn_fifo_param;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam int AF = 14;
    localparam int AE = 2;

    typedef struct {
        bit       clr;
        bit       w;
        bit       r;
        bit [7:0] d;
        int       cnt;
        bit       ovf;
        bit       udf;
    } vec_t;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    syn_fifo_param_if #(.data_width(DW), .addr_width(AW)) bus ();

    syn_fifo_param #(
        .data_width(DW),
        .addr_width(AW),
        .af_level(AF),
        .ae_level(AE)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    int       passed = 0;
    int       total = 0;
    vec_t     vecs[$];
    bit [7:0] mq[$];
    bit [7:0] exp_q[$];
    bit [7:0] exp_dout = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void add(bit c, bit w, bit r, bit [7:0] d, int cnt, bit ovf, bit udf);
        vec_t v;
        v.clr = c; v.w = w; v.r = r; v.d = d; v.cnt = cnt; v.ovf = ovf; v.udf = udf;
        vecs.push_back(v);
    endfunction

    task automatic step(input vec_t v);
        int  pre;
        bit  rd;
        bit  wr;
        clr         = v.clr;
        bus.w_en    = v.w;
        bus.r_en    = v.r;
        bus.data_in = v.d;
        pre = mq.size();
        rd  = !v.clr && v.r && (pre != 0);
        wr  = !v.clr && v.w && ((pre != DEPTH) || rd);
`ifdef SYN_FIFO_FWFT_EN
        #1;
        if (rd) check("fwft_pop_data", bus.data_out, mq[0]);
`endif
        if (rd) exp_q.push_back(mq.pop_front());
        if (wr) mq.push_back(v.d);
        if (v.clr) begin
            mq.delete();
            exp_q.delete();
        end
        @(posedge clk);
        #1;
        check("count", bus.count, v.cnt);
        check("full", bus.full, v.cnt == DEPTH);
        check("empty", bus.empty, v.cnt == 0);
        check("almost_full", bus.almost_full, v.cnt >= AF);
        check("almost_empty", bus.almost_empty, v.cnt <= AE);
        check("overflow", bus.overflow, v.ovf);
        check("underflow", bus.underflow, v.udf);
`ifdef SYN_FIFO_FWFT_EN
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (mq.size() != 0) check("fwft_head", bus.data_out, mq[0]);
`else
        if (v.clr) exp_dout = 8'h00;
        else if (exp_q.size() != 0) exp_dout = exp_q.pop_front();
        check("data_out", bus.data_out, exp_dout);
`endif
        clr      = 1'b0;
        bus.w_en = 1'b0;
        bus.r_en = 1'b0;
    endtask

    initial begin
        vec_t v;
        bus.w_en = 1'b0;
        bus.r_en = 1'b0;
        bus.data_in = '0;

        add(1, 0, 0, 8'h00, 0, 0, 0);
        for (int i = 1; i <= 16; i++) add(0, 1, 0, 8'(i), i, 0, 0);
        add(0, 1, 0, 8'hAA, 16, 1, 0);
        add(0, 0, 0, 8'h00, 16, 0, 0);
        for (int i = 1; i <= 16; i++) add(0, 0, 1, 8'h00, 16 - i, 0, 0);
        for (int i = 1; i <= 8; i++) add(0, 1, 0, 8'(8'h10 + i), i, 0, 0);
        for (int i = 1; i <= 8; i++) add(0, 0, 1, 8'h00, 8 - i, 0, 0);
        for (int i = 1; i <= 16; i++) add(0, 1, 0, 8'(8'h20 + i), i, 0, 0);
        add(0, 1, 1, 8'h55, 16, 0, 0);
        for (int i = 1; i <= 16; i++) add(0, 0, 1, 8'h00, 16 - i, 0, 0);
        add(0, 1, 1, 8'h66, 1, 0, 1);
        add(0, 0, 1, 8'h00, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 1, 8'h00, 0, 0, 1);
        add(0, 0, 0, 8'h00, 0, 0, 0);
        for (int i = 1; i <= 5; i++) add(0, 1, 0, 8'(8'h70 + i), i, 0, 0);
        add(1, 1, 0, 8'h99, 0, 0, 0);
        add(0, 1, 0, 8'h77, 1, 0, 0);
        add(0, 0, 1, 8'h00, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // Hand-written latency sequence: write into an empty FIFO, then read.
        v = '{clr: 1, w: 0, r: 0, d: 8'h00, cnt: 0, ovf: 0, udf: 0};
        step(v);
        v = '{clr: 0, w: 1, r: 0, d: 8'hC3, cnt: 1, ovf: 0, udf: 0};
        step(v);
`ifdef SYN_FIFO_FWFT_EN
        check("fwft_zero_latency", bus.data_out, 8'hC3);
`else
        check("std_not_early", bus.data_out, 8'h00);
`endif
        v = '{clr: 0, w: 1, r: 1, d: 8'h3C, cnt: 1, ovf: 0, udf: 0};
        step(v);
`ifdef SYN_FIFO_FWFT_EN
        check("fwft_next_head", bus.data_out, 8'h3C);
`else
        check("std_one_cycle", bus.data_out, 8'hC3);
`endif
        v = '{clr: 0, w: 0, r: 1, d: 8'h00, cnt: 0, ovf: 0, udf: 0};
        step(v);
`ifndef SYN_FIFO_FWFT_EN
        check("std_last_word", bus.data_out, 8'h3C);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
